// File: rtl/iq_pkg.sv
// Shared constants, framer state encoding and checksum helper for the I/Q stream loader.
package iq_pkg;

  localparam int IQ_W = 8;
  localparam logic [IQ_W-1:0] SYNC_BYTE = 8'hA5;
  localparam logic [IQ_W-1:0] MIDSCALE  = 8'h80;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    GET_I  = 2'd1,
    GET_Q  = 2'd2,
    GET_CK = 2'd3
  } iq_state_t;

  function automatic logic [IQ_W-1:0] frame_check(input logic [IQ_W-1:0] i_val,
                                                  input logic [IQ_W-1:0] q_val);
    return i_val ^ q_val;
  endfunction

endpackage

// File: rtl/iq_pair_fifo.sv
// Show-ahead FIFO of {I,Q} pairs; head is visible on pop_data whenever not empty.
module iq_pair_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty    = (level == LW'(0));
  assign full     = (level == LW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/iq_stream_loader.sv
// Frames SYNC,I,Q byte stream into pairs, buffers them and presents one pair per sample period.
// Optional IQ_CHECKSUM_EN adds a trailing CK byte (I^Q) and the frame_err flag.
module iq_stream_loader
  import iq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  input  logic [DIV_W-1:0]           rate_div,
  output logic [7:0]                 i_out,
  output logic [7:0]                 q_out,
  output logic                       sample_tick,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       frame_err
);

  iq_state_t        state;
  iq_state_t        state_nxt;
  logic             lat_i;
  logic             frame_ok;
  logic [IQ_W-1:0]  i_lat;
  logic             push;
  logic [2*IQ_W-1:0] pair;
  logic [2*IQ_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DIV_W-1:0] cnt;
  logic             tick;
  logic             pop;
`ifdef IQ_CHECKSUM_EN
  logic             lat_q;
  logic             ck_bad;
  logic [IQ_W-1:0]  q_lat;
`endif

  // Framer next-state and latch strobes.
  always_comb begin
    state_nxt = state;
    lat_i     = 1'b0;
    frame_ok  = 1'b0;
`ifdef IQ_CHECKSUM_EN
    lat_q     = 1'b0;
    ck_bad    = 1'b0;
`endif
    case (state)
      HUNT: begin
        if (byte_valid && (byte_in == SYNC_BYTE)) begin
          state_nxt = GET_I;
        end else begin
          state_nxt = HUNT;
        end
      end
      GET_I: begin
        if (byte_valid) begin
          lat_i     = 1'b1;
          state_nxt = GET_Q;
        end else begin
          state_nxt = GET_I;
        end
      end
      GET_Q: begin
        if (byte_valid) begin
`ifdef IQ_CHECKSUM_EN
          lat_q     = 1'b1;
          state_nxt = GET_CK;
`else
          frame_ok  = 1'b1;
          state_nxt = HUNT;
`endif
        end else begin
          state_nxt = GET_Q;
        end
      end
      GET_CK: begin
`ifdef IQ_CHECKSUM_EN
        if (byte_valid) begin
          if (byte_in == frame_check(i_lat, q_lat)) begin
            frame_ok = 1'b1;
          end else begin
            ck_bad   = 1'b1;
          end
          state_nxt = HUNT;
        end else begin
          state_nxt = GET_CK;
        end
`else
        state_nxt = HUNT;
`endif
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Framer state, byte latches and the registered pair handed to the FIFO.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= HUNT;
      i_lat <= '0;
      push  <= 1'b0;
      pair  <= '0;
    end else begin
      state <= state_nxt;
      push  <= frame_ok;
      if (lat_i) begin
        i_lat <= byte_in;
      end
      if (frame_ok) begin
`ifdef IQ_CHECKSUM_EN
        pair <= {i_lat, q_lat};
`else
        pair <= {i_lat, byte_in};
`endif
      end
    end
  end

`ifdef IQ_CHECKSUM_EN
  // Q byte is held until the checksum byte arrives; mismatch is sticky.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      q_lat     <= '0;
      frame_err <= 1'b0;
    end else begin
      if (lat_q) begin
        q_lat <= byte_in;
      end
      if (ck_bad) begin
        frame_err <= 1'b1;
      end
    end
  end
`else
  assign frame_err = 1'b0;
`endif

  // Using >= means lowering rate_div below the current count ticks right away.
  assign tick = (cnt >= rate_div);
  assign pop  = tick && !fifo_empty;

  // Sample-period divider.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  iq_pair_fifo #(
    .DEPTH (DEPTH),
    .W     (2*IQ_W)
  ) u_fifo (
    .clk       (clk),
    .areset    (areset),
    .push      (push),
    .push_data (pair),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Output pair, tick strobe and sticky status flags.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      i_out       <= MIDSCALE;
      q_out       <= MIDSCALE;
      sample_tick <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      sample_tick <= pop;
      if (pop) begin
        i_out <= head[2*IQ_W-1:IQ_W];
        q_out <= head[IQ_W-1:0];
      end
      if (tick && fifo_empty) begin
        underflow <= 1'b1;
      end
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iq_stream_loader.sv
// Self-checking bench for iq_stream_loader: vector table, scoreboard of expected pairs, corner sequences.
module tb_iq_stream_loader;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic [15:0] rate_div = 16'd3;
  logic [7:0]  i_out;
  logic [7:0]  q_out;
  logic        sample_tick;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        underflow;
  logic        frame_err;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] sb [$];
  logic [15:0] mon_exp;

  typedef struct {
    logic [7:0] lead;
    logic [7:0] i;
    logic [7:0] q;
    int         gap;
    logic [7:0] exp_i;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl [6];

  iq_stream_loader #(.DEPTH(16), .DIV_W(16)) dut (
    .clk         (clk),
    .areset      (areset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .rate_div    (rate_div),
    .i_out       (i_out),
    .q_out       (q_out),
    .sample_tick (sample_tick),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underflow   (underflow),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every sample_tick must deliver the oldest expected pair.
  always @(negedge clk) begin
    if (!areset && sample_tick) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tick: got i=%0h q=%0h, expected no tick", i_out, q_out);
      end else begin
        mon_exp = sb.pop_front();
        check("pair", {16'h0000, i_out, q_out}, {16'h0000, mon_exp});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'hA5;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] i, input logic [7:0] q, input int gap);
    send_byte(8'hA5, gap);
    send_byte(i, gap);
    send_byte(q, gap);
`ifdef IQ_CHECKSUM_EN
    send_byte(i ^ q, gap);
`endif
  endtask

  task automatic do_reset(input logic [15:0] rd);
    @(negedge clk);
    areset     = 1'b1;
    byte_valid = 1'b0;
    rate_div   = rd;
    sb.delete();
    @(negedge clk);
    check("rst_i", 32'(i_out), 32'h80);
    check("rst_q", 32'(q_out), 32'h80);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_flags", {29'd0, overflow, underflow, sample_tick}, 32'd0);
    areset = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    tbl[0] = '{8'h00, 8'h12, 8'h34, 0, 8'h12, 8'h34};
    tbl[1] = '{8'h77, 8'hA5, 8'hA5, 0, 8'hA5, 8'hA5};
    tbl[2] = '{8'h3C, 8'h01, 8'h02, 0, 8'h01, 8'h02};
    tbl[3] = '{8'hFF, 8'hFF, 8'h00, 2, 8'hFF, 8'h00};
    tbl[4] = '{8'hA4, 8'h80, 8'h7F, 1, 8'h80, 8'h7F};
    tbl[5] = '{8'h00, 8'h00, 8'hA5, 0, 8'h00, 8'hA5};

    // Idle after reset: outputs at midscale, underflow on the 4th cycle.
    do_reset(16'd3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("idle_tick", 32'(sample_tick), 32'd0);
      check("idle_uf", 32'(underflow), (c == 4) ? 32'd1 : 32'd0);
    end
    check("idle_i", 32'(i_out), 32'h80);
    check("idle_q", 32'(q_out), 32'h80);

    // Junk byte then one frame, slow divider.
    do_reset(16'd9);
    sb.push_back(16'h1234);
    send_byte(8'h00, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(negedge clk);
    check("one_level", 32'(fifo_level), 32'd1);
    check("one_notick", 32'(sample_tick), 32'd0);
    wait_drain(30);
    check("one_level_after", 32'(fifo_level), 32'd0);
    check("one_i_hold", 32'(i_out), 32'h12);

    // Table of framing patterns.
    do_reset(16'd3);
    for (int k = 0; k < 6; k++) begin
      sb.push_back({tbl[k].exp_i, tbl[k].exp_q});
      send_byte(tbl[k].lead, tbl[k].gap);
      send_frame(tbl[k].i, tbl[k].q, tbl[k].gap);
      wait_drain(40);
      check("tbl_level", 32'(fifo_level), 32'd0);
    end
    check("tbl_no_ovf", 32'(overflow), 32'd0);

    // 17 frames into a 16-deep FIFO with no readout.
    do_reset(16'hFFFF);
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) sb.push_back({8'(k), 8'(k) ^ 8'hF0});
      send_frame(8'(k), 8'(k) ^ 8'hF0, 0);
    end
    repeat (2) @(negedge clk);
    check("full_level", 32'(fifo_level), 32'd16);
    check("full_ovf", 32'(overflow), 32'd1);
    check("full_uf", 32'(underflow), 32'd0);
    rate_div = 16'd0;
    wait_drain(100);
    repeat (3) @(negedge clk);
    check("full_drained", 32'(fifo_level), 32'd0);

    // Reset in the middle of a frame discards the partial pair.
    send_byte(8'hA5, 0);
    send_byte(8'h12, 0);
    areset = 1'b1;
    #1;
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_uf", 32'(underflow), 32'd0);
    check("mid_rst_i", 32'(i_out), 32'h80);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    @(negedge clk);
    rate_div = 16'd3;
    areset   = 1'b0;
    sb.push_back(16'h5678);
    send_frame(8'h56, 8'h78, 0);
    wait_drain(40);
    repeat (8) @(negedge clk);
    check("mid_i", 32'(i_out), 32'h56);
    check("mid_q", 32'(q_out), 32'h78);

`ifdef IQ_CHECKSUM_EN
    do_reset(16'd3);
    sb.push_back(16'h1234);
    send_byte(8'hA5, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h26, 0);
    wait_drain(40);
    check("ck_good_err", 32'(frame_err), 32'd0);
    send_byte(8'hA5, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    check("ck_bad_err", 32'(frame_err), 32'd1);
    check("ck_bad_level", 32'(fifo_level), 32'd0);
    repeat (10) @(negedge clk);
`else
    check("no_ck_err", 32'(frame_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iq_stream_loader.md
Name: iq_stream_loader

Overview:
- Upstream feeder for the I/Q DAC calculator.
- Takes the byte stream delivered by the FT245R FIFO reader and frames it into I/Q sample pairs.
- Buffers pairs in a small FIFO.
- Presents one pair on registered i/q outputs per programmable sample period, replacing the free-running test pattern that currently drives i.

Parameters:
- DEPTH, 16: FIFO depth in I/Q pairs; must be a power of 2, ≥2.
- DIV_W, 16: width of the sample-rate divider.

Ports:
- clk  in  1  system clock, same domain as the FT245R reader.
- areset  in  1  asynchronous reset, active-high.
- byte_in  in  8  received USB byte.
- byte_valid  in  1  one-cycle strobe; byte_in is valid on this cycle.
- rate_div  in  DIV_W  sample period minus 1, in clk cycles.
- i_out  out  8  current I sample; feeds i of iqcalc.
- q_out  out  8  current Q sample; feeds q of iqcalc.
- sample_tick  out  1  one-cycle pulse when a new pair is loaded.
- fifo_level  out  $clog2(DEPTH+1)  pairs currently buffered.
- overflow  out  1  sticky; a completed pair was dropped because the FIFO was full.
- underflow  out  1  sticky; a sample period elapsed with the FIFO empty.
- frame_err  out  1  sticky; checksum mismatch (only with feature enabled, else tied 0).

Behaviour:
- Clock and reset: one clock, clk. Reset areset is asynchronous and active-high.
- While areset is asserted:
  - i_out=8'h80, q_out=8'h80.
  - sample_tick=0, fifo_level=0, overflow/underflow/frame_err=0.
  - FSM in HUNT, divider counter 0, FIFO emptied.
- Reset mid-frame discards the partial frame. There is no resync beyond HUNT.
- Frame format: SYNC (8'hA5), I, Q. Bytes are consumed only on byte_valid cycles.
- Framing FSM:
  - HUNT: byte==SYNC -> GET_I. Any other byte is ignored and the FSM stays in HUNT.
  - GET_I: latch I -> GET_Q.
  - GET_Q: latch Q, issue push -> HUNT.
  - A byte value of 8'hA5 inside I or Q is data, not a sync.
- Push is issued in the cycle after the Q byte (registered pair).
  - If the FIFO is full and no pop occurs that cycle: pair dropped, overflow set.
- Rate divider:
  - Counter increments every cycle.
  - When counter >= rate_div: counter <= 0 and a tick occurs.
  - rate_div=0 gives a tick every cycle.
  - Lowering rate_div below the current count produces a tick on the next cycle.
- On a tick, FIFO non-empty: pop head. i_out/q_out take the head value at that clock edge. sample_tick is high for that one cycle, coincident with the new values (zero-latency show-ahead FIFO).
- On a tick, FIFO empty: i_out/q_out hold, sample_tick stays 0, underflow set.
- Simultaneous push and pop:
  - Full FIFO: both succeed, level unchanged, no overflow.
  - Empty FIFO: no bypass; the pop sees empty -> underflow, and the push lands.
- fifo_level updates the cycle after each push/pop. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro IQ_CHECKSUM_EN.
- Defined:
  - Frame becomes SYNC, I, Q, CK with extra state GET_CK.
  - Push only if CK == I^Q.
  - Mismatch: frame dropped, frame_err set, FSM -> HUNT.
- Undefined: 3-byte frames, frame_err tied 0, no GET_CK state.

Decomposition:
- Package iq_pkg:
  - IQ_W=8.
  - SYNC_BYTE=8'hA5.
  - MIDSCALE=8'h80.
  - Framer state encoding: HUNT, GET_I, GET_Q, GET_CK.
- Sub-module iq_pair_fifo: synchronous show-ahead FIFO, 16-bit entries {I,Q}, DEPTH deep, with push/pop/full/empty/level and asynchronous areset.

Test Plan:
- Reset then idle with rate_div=3 -> i_out=q_out=8'h80; underflow set after 4 cycles; sample_tick never pulses.
- Bytes 00,A5,12,34 with rate_div=9 -> one pair buffered (level=1); on next tick i_out=8'h12, q_out=8'h34, sample_tick one cycle, level=0.
- Frame A5,A5,A5 -> pair I=A5, Q=A5 accepted; FSM back in HUNT.
- 17 back-to-back frames, DEPTH=16, rate_div=16'hFFFF -> level=16, overflow set, first 16 pairs intact in order on readout.
- areset asserted after A5,12 then frame A5,56,78 -> only 56/78 emerges; flags cleared.
- With IQ_CHECKSUM_EN: A5,12,34,26 accepted; A5,12,34,00 dropped and frame_err set.
